fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 12, meaning program counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 12, meaning instruction word width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, meaning fetch-queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port fetch_en  input  1  permits new fetches when high.
REQ-008 SHALL have port imem_addr  output  PC_WIDTH  current PC, driven to the combinational instruction memory.
REQ-009 SHALL have port imem_instr  input  INSTR_WIDTH  instruction word for imem_addr, valid in the same cycle.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-011 SHALL have port redirect_pc  input  PC_WIDTH  redirect target.
REQ-012 SHALL have port id_valid  output  1  queue head holds a valid instruction for decode.
REQ-013 SHALL have port id_ready  input  1  decode accepts the head entry this cycle.
REQ-014 SHALL have port id_pc  output  PC_WIDTH  PC of the head entry.
REQ-015 SHALL have port id_instr  output  INSTR_WIDTH  instruction of the head entry.

Function
REQ-016 SHALL push {imem_addr, imem_instr} into the queue and increment the PC by 1 modulo 2^PC_WIDTH in any cycle where fetch_en=1, the queue is not full, and redirect_valid=0.
REQ-017 SHALL hold the PC and not push while the queue is full or fetch_en=0.
REQ-018 SHALL pop the head entry in any cycle where id_valid=1 and id_ready=1.
REQ-019 SHALL drive id_valid=1 exactly when the occupancy count is nonzero, with id_pc/id_instr taken combinationally from registered head storage (no same-cycle bypass of imem to id_*).
REQ-020 SHALL give fetch-to-decode latency of one cycle: an instruction pushed in cycle N is visible at id_* in cycle N+1 at the earliest.
REQ-021 SHALL allow simultaneous push and pop when not full; occupancy then stays unchanged.
REQ-022 SHALL NOT push when full, even if a pop occurs in the same cycle; the push occurs in the following cycle.
REQ-023 SHALL, on redirect_valid=1, discard all queued entries (occupancy=0 next cycle), load PC with redirect_pc, perform no push, and ignore any pop in that cycle; redirect has priority over every other event.
REQ-024 SHALL, after a redirect in cycle N, push redirect_pc in cycle N+1, and present it at id_* in cycle N+2.
REQ-025 SHALL keep read/write pointers one bit wider than log2(QUEUE_DEPTH) and let them wrap naturally; full is signalled by equal index bits with differing MSBs.
REQ-026 SHALL leave id_pc/id_instr contents unspecified while id_valid=0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously set PC=RESET_PC, both pointers=0, id_valid=0, and imem_addr=RESET_PC.
REQ-028 SHALL, on reset assertion mid-operation, discard all queued entries with no partial state retained.
REQ-029 SHALL, in the first clock after reset_n rises with fetch_en=1, push RESET_PC, with id_valid=1 in the cycle after that.

Configuration
REQ-030 SHALL, when FETCH_PERF_CNT_EN is defined, add 32-bit outputs perf_fetched (count of pushes) and perf_stalls (count of cycles with fetch_en=1 and the queue full), both reset to 0, wrapping at 2^32, and cleared on reset only.
REQ-031 SHALL, when FETCH_PERF_CNT_EN is undefined, omit both ports and counters entirely, with no other behavioural change.

Structure
REQ-032 SHALL place the fetch-entry struct type {pc, instr} and the pointer-width function/constant in the shared CPU package.
REQ-033 SHALL implement the queue as one sub-module, fetch_queue (parametrised by depth and entry width), with PC and redirect logic in fetch_unit.

Verification
REQ-034 SHALL cover reset release with fetch_en=1 and id_ready=1: id_pc sequence 0,1,2,3 on consecutive cycles starting the second cycle after release.
REQ-035 SHALL cover id_ready=0 for 8 cycles, QUEUE_DEPTH=4: queue holds PCs 0..3, imem_addr holds at 4, and after id_ready=1 the output is 0,1,2,3,4 with no gap or duplicate.
REQ-036 SHALL cover redirect_valid=1 with redirect_pc=0x80 while 3 entries are queued: id_valid=0 next cycle, then id_pc=0x80 two cycles after the redirect, with none of the old entries ever emitted.
REQ-037 SHALL cover PC wrap with redirect_pc=0xFFE, PC_WIDTH=12: id_pc sequence 0xFFE, 0xFFF, 0x000.
REQ-038 SHALL cover reset_n pulsed low mid-stream while full: id_valid=0 immediately (asynchronously), then PC restarts at RESET_PC.
REQ-039 SHALL cover, with FETCH_PERF_CNT_EN defined, the scenario of REQ-035: perf_stalls counts exactly the full-queue cycles and perf_fetched equals the number of pushes.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: the fetch-entry type and the helper that sizes queue pointers.
package fetch_unit_pkg;

  localparam int CPU_PC_WIDTH    = 12;
  localparam int CPU_INSTR_WIDTH = 12;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [CPU_PC_WIDTH-1:0]    pc;
    logic [CPU_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Queue pointers carry one extra wrap bit, so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: a circular buffer whose pointers are one bit wider than the index.
// Full means the index bits are equal and the wrap bits differ. A flush empties
// the queue and takes priority over a push or pop in the same cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        do_push, do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign head_data = mem[rd_ptr[IW-1:0]];
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;

  // Pointer update: reset and flush both return the queue to empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are never visible unless the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, applies redirects and feeds the fetch queue.
// The imem read is combinational. Its result goes only into the queue, so
// decode sees an instruction one cycle after it is fetched at the earliest.
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched and
// perf_stalls counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   PC_WIDTH    = CPU_PC_WIDTH,
  parameter int                   INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stalls
`endif
);

  localparam int EW = PC_WIDTH + INSTR_WIDTH;

  logic [PC_WIDTH-1:0] pc;
  logic [EW-1:0]       head;
  logic                q_full, q_empty, push, pop;

  assign imem_addr = pc;
  // A redirect takes priority: it blocks the push, and the queue flush cancels any pop.
  assign push      = fetch_en && !q_full && !redirect_valid;
  assign pop       = id_ready && !q_empty;
  assign id_valid  = !q_empty;
  assign id_pc     = head[EW-1:INSTR_WIDTH];
  assign id_instr  = head[INSTR_WIDTH-1:0];

  // PC: load the redirect target, otherwise step past each instruction pushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + PC_WIDTH'(1);
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({pc, imem_instr}),
    .pop       (pop),
    .head_data (head),
    .empty     (q_empty),
    .full      (q_full)
  );

`ifdef FETCH_PERF_CNT_EN
  // Perf counters: pushes, and cycles where fetching is wanted but the queue is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push)               perf_fetched <= perf_fetched + 32'd1;
      if (fetch_en && q_full) perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-level reference model checked on every cycle,
// plus literal expectations for the directed scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PCW   = 12;
  localparam int IW    = 12;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           fetch_en = 1'b0;
  logic           redirect_valid = 1'b0;
  logic           id_ready = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic [PCW-1:0] imem_addr, id_pc;
  logic [IW-1:0]  imem_instr, id_instr;
  logic           id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]    perf_fetched, perf_stalls;
`endif

  always #5 clk = ~clk;

  // Instruction memory stub: each word is a fixed function of its address.
  function automatic logic [IW-1:0] rom(input logic [PCW-1:0] a);
    return a ^ 12'h5A3;
  endfunction
  assign imem_instr = rom(imem_addr);

  fetch_unit #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (12'h000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
`endif
  );

  // Reference model: a queue of entries plus the next fetch address.
  fetch_entry_t mq[$];
  logic [PCW-1:0] mpc;
  int unsigned    m_fetched, m_stalls;
  bit             m_full;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mpc = '0;
      m_fetched = 0;
      m_stalls = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      if (fetch_en && m_full) m_stalls++;
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc;
      end else begin
        if (mq.size() != 0 && id_ready) void'(mq.pop_front());
        if (fetch_en && !m_full) begin
          mq.push_back('{pc: mpc, instr: rom(mpc)});
          mpc = mpc + 12'd1;
          m_fetched++;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'h000);
    end else begin
      chk("imem_addr", 32'(imem_addr), 32'(mpc));
      chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("id_pc", 32'(id_pc), 32'(mq[0].pc));
        chk("id_instr", 32'(id_instr), 32'(mq[0].instr));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stalls", perf_stalls, m_stalls);
`endif
    end
  end

  // Log of PCs that decode actually accepts.
  logic [PCW-1:0] log_q[$];
  always @(posedge clk) begin
    if (reset_n && id_valid && id_ready && !redirect_valid) log_q.push_back(id_pc);
  end

  function automatic logic [31:0] lg(input int i);
    return (i < log_q.size()) ? 32'(log_q[i]) : 32'hBAD0BAD;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset release with the fetch path fully open: accepted PCs 0,1,2,3.
    fetch_en = 1'b1;
    id_ready = 1'b1;
    step(2);
    reset_n = 1'b1;
    log_q.delete();
    chk("s1_valid_at_release", 32'(id_valid), 32'd0);
    chk("s1_addr_at_release", 32'(imem_addr), 32'h000);
    step(1);
    chk("s1_first_valid", 32'(id_valid), 32'd1);
    chk("s1_first_pc", 32'(id_pc), 32'h000);
    step(4);
    chk("s1_log0", lg(0), 32'h000);
    chk("s1_log1", lg(1), 32'h001);
    chk("s1_log2", lg(2), 32'h002);
    chk("s1_log3", lg(3), 32'h003);

    // Decode stalled for 8 cycles: the queue fills and the PC parks at 4.
    reset_n = 1'b0;
    id_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(8);
    chk("s2_addr_held", 32'(imem_addr), 32'h004);
    chk("s2_head_pc", 32'(id_pc), 32'h000);
`ifdef FETCH_PERF_CNT_EN
    chk("s2_perf_fetched", perf_fetched, 32'd4);
    chk("s2_perf_stalls", perf_stalls, 32'd4);
`endif
    log_q.delete();
    id_ready = 1'b1;
    step(5);
    chk("s2_log_len", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("s2_log", lg(i), 32'(i));

    // Redirect to 0x80 while three entries are queued.
    reset_n = 1'b0;
    id_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 12'h080;
    id_ready = 1'b1;
    log_q.delete();
    step(1);
    redirect_valid = 1'b0;
    chk("s3_flushed", 32'(id_valid), 32'd0);
    chk("s3_addr", 32'(imem_addr), 32'h080);
    step(1);
    chk("s3_valid", 32'(id_valid), 32'd1);
    chk("s3_pc", 32'(id_pc), 32'h080);
    step(3);
    chk("s3_log_len", 32'(log_q.size()), 32'd3);
    chk("s3_log0", lg(0), 32'h080);
    chk("s3_log1", lg(1), 32'h081);
    chk("s3_log2", lg(2), 32'h082);

    // PC wrap: redirect to 0xFFE.
    redirect_valid = 1'b1;
    redirect_pc = 12'hFFE;
    step(1);
    redirect_valid = 1'b0;
    log_q.delete();
    step(4);
    chk("s4_log0", lg(0), 32'hFFE);
    chk("s4_log1", lg(1), 32'hFFF);
    chk("s4_log2", lg(2), 32'h000);

    // Reset pulsed mid-stream while the queue is full.
    id_ready = 1'b0;
    step(6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_async_valid", 32'(id_valid), 32'd0);
    chk("s5_async_addr", 32'(imem_addr), 32'h000);
    step(1);
    reset_n = 1'b1;
    id_ready = 1'b1;
    log_q.delete();
    step(4);
    chk("s5_log0", lg(0), 32'h000);
    chk("s5_log1", lg(1), 32'h001);
    chk("s5_log2", lg(2), 32'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
